spike_aer_arbiter: RTL and testbench
====================================

Name: spike_aer_arbiter

Overview:
- Collects one-cycle spike pulses from N_NEURONS alif neuron instances.
- Latches each pulse as a pending event with a capture timestamp.
- Serialises pending events onto a single Address-Event Representation (AER) output using round-robin arbitration and a valid/ready handshake.
- Sits between the neuron array and the off-chip or uio spike bus. Drop accounting covers back-pressure loss.

Parameters:
- N_NEURONS, 8, number of spike inputs (power of two, 2..16).
- ADDR_W, 3, address width; equals log2(N_NEURONS).
- TS_W, 8, timestamp counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- spike_in  input  N_NEURONS  per-neuron spike pulses; sampled each edge.
- enable  input  1  1 = capture spikes and advance the timestamp.
- aer_ready  input  1  consumer accepts the current event.
- clear_overflow  input  1  synchronous clear of overflow and drop_count.
- aer_valid  output  1  an event is presented on aer_addr/aer_ts.
- aer_addr  output  ADDR_W  neuron index of the presented event.
- aer_ts  output  TS_W  capture timestamp of the presented event.
- pending  output  N_NEURONS  pending-event bitmap (registered).
- overflow  output  1  sticky; set when any spike is dropped.
- drop_count  output  8  saturating count of dropped spikes.

Behaviour:
Reset (asynchronous):
- ts, pending, ts_mem[*], rr_ptr, aer_valid, aer_addr, aer_ts, overflow and drop_count are all cleared to 0.

Timestamp:
- ts increments by 1 on each edge while enable=1.
- Wraps from 2^TS_W-1 to 0.
- Frozen while enable=0.

Capture (enable=1, per bit i):
- If spike_in[i]=1 and pending[i]=0: set pending[i] and write ts_mem[i] = current ts (the pre-increment value).
- If spike_in[i]=1 and pending[i]=1 and i is being granted this edge: pending[i] stays 1 and ts_mem[i] takes the new ts. This is a re-queue, not a drop.
- If spike_in[i]=1 and pending[i]=1 and i is not granted: it is a drop. ts_mem[i] is unchanged and the spike is counted as dropped.
- With enable=0, spike_in is ignored entirely: no capture and no drop.

Output slot (two states, EMPTY = aer_valid 0, FULL = aer_valid 1):
- A load occurs when (aer_valid=0) or (aer_valid & aer_ready), and pending != 0.
- Selection considers the registered pending bitmap only, never same-cycle spike_in.
- Selected index g = first set pending bit found scanning rr_ptr, rr_ptr+1, ..., wrapping modulo N_NEURONS.
- On load:
  - aer_addr <= g
  - aer_ts <= ts_mem[g]
  - aer_valid <= 1
  - pending[g] cleared (unless re-queued as above)
  - rr_ptr <= (g+1) mod N_NEURONS
- Handshake with pending == 0: aer_valid <= 0.
- While aer_valid=1 and aer_ready=0: aer_addr and aer_ts are held stable and no grant occurs.
- aer_ready while aer_valid=0 has no effect.
- Minimum latency: spike high in cycle k → pending visible after edge k → aer_valid visible after edge k+1.
- Sustained throughput: 1 event per cycle with aer_ready held at 1.

Drop accounting:
- On each edge, drop_count += popcount(dropped bits), saturating at 255.
- overflow is set when the dropped popcount is greater than 0.
- clear_overflow=1 zeroes both registers at the edge.
- If drops occur on the same edge as clear_overflow: overflow=1 and drop_count = that edge's drop popcount.

Arbitration, enable and reset mid-operation:
- rr_ptr only changes on a grant.
- enable=0 does not stall draining; existing pending events continue to be granted.
- Reset mid-transfer discards the presented event and all pending events.

Test Plan:
1. Single spike: reset, enable=1, aer_ready=1, pulse spike_in=8'h04 at ts=5 → aer_valid=1 two edges later, aer_addr=2, aer_ts=5; pending=0 afterwards.
2. Round-robin fairness: spike_in=8'hFF for one cycle with aer_ready=1 → addresses 0,1,...,7 on 8 consecutive cycles, all with the same aer_ts. Then spike_in=8'h81 → addr 0, then 7 (rr_ptr was 0 after wrap).
3. Back-pressure hold: aer_ready=0 with event addr 3 presented for 5 cycles → aer_addr and aer_ts stable and aer_valid stays 1. Raise aer_ready → next pending index taken the following cycle.
4. Drop and saturation:
   - aer_ready=0, neuron 1 pending (not presented), spike_in[1] pulsed 3 times → drop_count=3, overflow=1.
   - 300 further drops → drop_count=255.
   - clear_overflow → both 0. Drop coincident with clear_overflow → overflow=1, drop_count=1.
5. Re-queue and timestamp wrap: neuron 4 granted on the same edge spike_in[4]=1 at ts=255 → no drop, pending[4]=1, next event for addr 4 has aer_ts=255. The following event captures ts=0.
6. Enable and reset: enable=0 with spike pulses → pending unchanged, ts frozen, and existing events still drain. Assert reset_n low mid-handshake (asynchronously, between edges) → aer_valid, pending, overflow and ts all 0 immediately.

Source files
------------

// File: rtl/spike_aer_arbiter.sv
// spike_aer_arbiter
//
// Collects one-cycle spike pulses from an array of neurons and keeps one
// pending event per neuron, stamped with the timestamp of its capture.
// Pending events are serialised onto a single AER output slot using
// round-robin arbitration and a valid/ready handshake. Spikes that arrive
// while their neuron already has an event waiting are counted as drops.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   spike_in       per-neuron spike pulses, sampled every edge
//   enable         1 = capture spikes and advance the timestamp
//   aer_ready      consumer accepts the presented event
//   clear_overflow synchronous clear of overflow and drop_count
//   aer_valid      an event is presented on aer_addr / aer_ts
//   aer_addr       neuron index of the presented event
//   aer_ts         capture timestamp of the presented event
//   pending        registered pending-event bitmap
//   overflow       sticky flag, set when any spike is dropped
//   drop_count     saturating count of dropped spikes
module spike_aer_arbiter #(
    parameter int N_NEURONS = 8,
    parameter int ADDR_W    = 3,
    parameter int TS_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_NEURONS-1:0] spike_in,
    input  logic                 enable,
    input  logic                 aer_ready,
    input  logic                 clear_overflow,
    output logic                 aer_valid,
    output logic [ADDR_W-1:0]    aer_addr,
    output logic [TS_W-1:0]      aer_ts,
    output logic [N_NEURONS-1:0] pending,
    output logic                 overflow,
    output logic [7:0]           drop_count
);

    localparam int CNT_W = $clog2(N_NEURONS + 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t state, state_next;

    logic [TS_W-1:0]      ts;
    logic [TS_W-1:0]      ts_mem [N_NEURONS];
    logic [ADDR_W-1:0]    rr_ptr;

    logic [ADDR_W-1:0]    cand;
    logic [ADDR_W-1:0]    grant_idx;
    logic                 found;
    logic                 slot_free;
    logic                 grant;
    logic [N_NEURONS-1:0] grant_mask;
    logic [N_NEURONS-1:0] capture;
    logic [N_NEURONS-1:0] dropped;
    logic [N_NEURONS-1:0] write_ts;
    logic [N_NEURONS-1:0] pending_next;
    logic [CNT_W-1:0]     drop_inc;

    function automatic logic [CNT_W-1:0] popcount(input logic [N_NEURONS-1:0] vec);
        logic [CNT_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            acc = acc + CNT_W'(vec[i]);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [CNT_W-1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, base} + 9'(inc);
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // ---- Arbitration: first pending bit at or after rr_ptr, wrapping ----
    // The index arithmetic wraps naturally because N_NEURONS = 2**ADDR_W.
    always_comb begin
        cand      = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < N_NEURONS; k++) begin
            cand = rr_ptr + ADDR_W'(k);
            if (!found && pending[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign aer_valid = (state == FULL);
    assign slot_free = (state == EMPTY) || aer_ready;
    assign grant     = slot_free && found;

    always_comb begin
        grant_mask = '0;
        if (grant) begin
            grant_mask[grant_idx] = 1'b1;
        end
    end

    // A spike on an already-pending neuron is a drop unless that neuron is
    // being granted this edge, in which case it simply re-queues.
    assign capture      = {N_NEURONS{enable}} & spike_in;
    assign dropped      = capture & pending & ~grant_mask;
    assign write_ts     = capture & ~dropped;
    assign pending_next = (pending & ~grant_mask) | capture;
    assign drop_inc     = popcount(dropped);

    // ---- Output slot FSM ----
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (grant) state_next = FULL;
            FULL:  if (aer_ready) state_next = found ? FULL : EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // ---- Register stage: timestamp, pending bitmap, slot contents ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts       <= '0;
            pending  <= '0;
            rr_ptr   <= '0;
            aer_addr <= '0;
            aer_ts   <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                ts_mem[i] <= '0;
            end
        end else begin
            if (enable) begin
                ts <= ts + 1'b1;
            end
            pending <= pending_next;
            for (int i = 0; i < N_NEURONS; i++) begin
                if (write_ts[i]) begin
                    ts_mem[i] <= ts;
                end
            end
            if (grant) begin
                aer_addr <= grant_idx;
                aer_ts   <= ts_mem[grant_idx];
                rr_ptr   <= grant_idx + 1'b1;
            end
        end
    end

    // ---- Drop accounting ----
    // A clear on the same edge as a drop leaves only that edge's drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            overflow   <= (overflow && !clear_overflow) || (drop_inc != '0);
            drop_count <= sat_add8(clear_overflow ? 8'd0 : drop_count, drop_inc);
        end
    end

endmodule

// File: tb/tb_spike_aer_arbiter.sv
// Directed self-checking bench for spike_aer_arbiter. Inputs change 1 time
// unit after each rising edge; outputs are sampled at that same point.
module tb_spike_aer_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] spike_in = '0;
    logic       enable = 1'b0;
    logic       aer_ready = 1'b0;
    logic       clear_overflow = 1'b0;
    logic       aer_valid;
    logic [2:0] aer_addr;
    logic [7:0] aer_ts;
    logic [7:0] pending;
    logic       overflow;
    logic [7:0] drop_count;

    int checks = 0;
    int errors = 0;

    spike_aer_arbiter #(.N_NEURONS(8), .ADDR_W(3), .TS_W(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .spike_in       (spike_in),
        .enable         (enable),
        .aer_ready      (aer_ready),
        .clear_overflow (clear_overflow),
        .aer_valid      (aer_valid),
        .aer_addr       (aer_addr),
        .aer_ts         (aer_ts),
        .pending        (pending),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        spike_in = '0;
        enable = 1'b0;
        aer_ready = 1'b0;
        clear_overflow = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (aer_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", aer_valid); end
        checks++; if (aer_addr !== 3'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", aer_addr); end
        checks++; if (aer_ts !== 8'd0) begin errors++; $display("FAIL reset_ts got=%0d exp=0", aer_ts); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending got=%h exp=00", pending); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop_count got=%0d exp=0", drop_count); end
    endtask

    task automatic test_single_spike();
        do_reset();
        enable = 1'b1;
        aer_ready = 1'b1;
        step(5);
        spike_in = 8'h04;
        step(1);
        spike_in = 8'h00;
        checks++; if (pending !== 8'h04) begin errors++; $display("FAIL single_pending got=%h exp=04", pending); end
        checks++; if (aer_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early got=%b exp=0", aer_valid); end
        step(1);
        checks++; if (aer_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", aer_valid); end
        checks++; if (aer_addr !== 3'd2) begin errors++; $display("FAIL single_addr got=%0d exp=2", aer_addr); end
        checks++; if (aer_ts !== 8'd5) begin errors++; $display("FAIL single_ts got=%0d exp=5", aer_ts); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL single_pending_after got=%h exp=00", pending); end
        step(1);
        checks++; if (aer_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got=%b exp=0", aer_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        enable = 1'b1;
        aer_ready = 1'b1;
        spike_in = 8'hFF;
        step(1);
        spike_in = 8'h00;
        for (int i = 0; i < 8; i++) begin
            step(1);
            checks++; if (aer_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got=%b exp=1", i, aer_valid); end
            checks++; if (aer_addr !== 3'(i)) begin errors++; $display("FAIL rr_addr[%0d] got=%0d exp=%0d", i, aer_addr, i); end
            checks++; if (aer_ts !== 8'd0) begin errors++; $display("FAIL rr_ts[%0d] got=%0d exp=0", i, aer_ts); end
        end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL rr_pending_drained got=%h exp=00", pending); end
        spike_in = 8'h81;
        step(1);
        spike_in = 8'h00;
        step(1);
        checks++; if (aer_addr !== 3'd0) begin errors++; $display("FAIL rr81_first got=%0d exp=0", aer_addr); end
        checks++; if (aer_ts !== 8'd9) begin errors++; $display("FAIL rr81_ts got=%0d exp=9", aer_ts); end
        step(1);
        checks++; if (aer_addr !== 3'd7) begin errors++; $display("FAIL rr81_second got=%0d exp=7", aer_addr); end
        checks++; if (aer_valid !== 1'b1) begin errors++; $display("FAIL rr81_valid got=%b exp=1", aer_valid); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        enable = 1'b1;
        aer_ready = 1'b0;
        spike_in = 8'h08;
        step(1);
        spike_in = 8'h20;
        step(1);
        spike_in = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step(1);
            checks++; if (aer_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, aer_valid); end
            checks++; if (aer_addr !== 3'd3) begin errors++; $display("FAIL bp_addr[%0d] got=%0d exp=3", i, aer_addr); end
            checks++; if (aer_ts !== 8'd0) begin errors++; $display("FAIL bp_ts[%0d] got=%0d exp=0", i, aer_ts); end
        end
        checks++; if (pending !== 8'h20) begin errors++; $display("FAIL bp_pending got=%h exp=20", pending); end
        aer_ready = 1'b1;
        step(1);
        checks++; if (aer_addr !== 3'd5) begin errors++; $display("FAIL bp_next_addr got=%0d exp=5", aer_addr); end
        checks++; if (aer_ts !== 8'd1) begin errors++; $display("FAIL bp_next_ts got=%0d exp=1", aer_ts); end
        step(1);
        checks++; if (aer_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", aer_valid); end
    endtask

    task automatic test_drops();
        do_reset();
        enable = 1'b1;
        aer_ready = 1'b0;
        spike_in = 8'h03;
        step(1);
        spike_in = 8'h00;
        step(1);
        checks++; if (pending !== 8'h02) begin errors++; $display("FAIL drop_setup_pending got=%h exp=02", pending); end
        spike_in = 8'h02;
        step(3);
        checks++; if (drop_count !== 8'd3) begin errors++; $display("FAIL drop_count3 got=%0d exp=3", drop_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drop_overflow got=%b exp=1", overflow); end
        step(300);
        checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_saturate got=%0d exp=255", drop_count); end
        spike_in = 8'h00;
        clear_overflow = 1'b1;
        step(1);
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL clear_count got=%0d exp=0", drop_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clear_overflow got=%b exp=0", overflow); end
        spike_in = 8'h02;
        step(1);
        spike_in = 8'h00;
        clear_overflow = 1'b0;
        checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL clear_coincident_count got=%0d exp=1", drop_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clear_coincident_overflow got=%b exp=1", overflow); end
        checks++; if (aer_addr !== 3'd0) begin errors++; $display("FAIL drop_held_addr got=%0d exp=0", aer_addr); end
    endtask

    task automatic test_requeue_wrap();
        do_reset();
        enable = 1'b1;
        aer_ready = 1'b1;
        step(254);
        spike_in = 8'h10;
        step(1);
        step(1);
        checks++; if (aer_addr !== 3'd4) begin errors++; $display("FAIL rq_addr got=%0d exp=4", aer_addr); end
        checks++; if (aer_ts !== 8'd254) begin errors++; $display("FAIL rq_ts1 got=%0d exp=254", aer_ts); end
        checks++; if (pending !== 8'h10) begin errors++; $display("FAIL rq_pending got=%h exp=10", pending); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL rq_no_drop got=%0d exp=0", drop_count); end
        step(1);
        spike_in = 8'h00;
        checks++; if (aer_ts !== 8'd255) begin errors++; $display("FAIL rq_ts255 got=%0d exp=255", aer_ts); end
        checks++; if (aer_addr !== 3'd4) begin errors++; $display("FAIL rq_addr2 got=%0d exp=4", aer_addr); end
        step(1);
        checks++; if (aer_ts !== 8'd0) begin errors++; $display("FAIL rq_ts_wrap got=%0d exp=0", aer_ts); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL rq_pending_end got=%h exp=00", pending); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rq_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_enable_reset();
        do_reset();
        enable = 1'b1;
        aer_ready = 1'b0;
        spike_in = 8'h06;
        step(1);
        spike_in = 8'h00;
        step(1);
        enable = 1'b0;
        spike_in = 8'hFF;
        step(1);
        checks++; if (pending !== 8'h04) begin errors++; $display("FAIL en_pending_frozen got=%h exp=04", pending); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL en_no_drop got=%0d exp=0", drop_count); end
        checks++; if (aer_addr !== 3'd1) begin errors++; $display("FAIL en_held_addr got=%0d exp=1", aer_addr); end
        aer_ready = 1'b1;
        step(1);
        checks++; if (aer_addr !== 3'd2) begin errors++; $display("FAIL en_drain_addr got=%0d exp=2", aer_addr); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL en_drain_pending got=%h exp=00", pending); end
        enable = 1'b1;
        spike_in = 8'h08;
        step(1);
        spike_in = 8'h00;
        step(1);
        checks++; if (aer_ts !== 8'd2) begin errors++; $display("FAIL en_ts_frozen got=%0d exp=2", aer_ts); end
        aer_ready = 1'b0;
        spike_in = 8'h10;
        step(2);
        spike_in = 8'h00;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL rst_pre_overflow got=%b exp=1", overflow); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (aer_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got=%b exp=0", aer_valid); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL rst_async_pending got=%h exp=00", pending); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_async_overflow got=%b exp=0", overflow); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL rst_async_count got=%0d exp=0", drop_count); end
        @(negedge clk);
        reset_n = 1'b1;
        enable = 1'b1;
        aer_ready = 1'b1;
        spike_in = 8'h01;
        step(1);
        spike_in = 8'h00;
        step(1);
        checks++; if (aer_ts !== 8'd0) begin errors++; $display("FAIL rst_ts_cleared got=%0d exp=0", aer_ts); end
        checks++; if (aer_addr !== 3'd0) begin errors++; $display("FAIL rst_rr_cleared got=%0d exp=0", aer_addr); end
    endtask

    initial begin
        test_reset();
        test_single_spike();
        test_round_robin();
        test_back_pressure();
        test_drops();
        test_requeue_wrap();
        test_enable_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
